array_sort_check_datapath: RTL and testbench

Datapath partner of the array-sort-check controller. It holds the array base address and length, steps an element index under controller command, drives the word address to the array memory, and keeps the previously read element so it can compare adjacent elements. It returns the three status flags the controller branches on: `inversion_found`, `end_of_array` and `zero_length_array`.

---
 rtl/array_sort_check_pkg.sv | 18 +
 rtl/array_sort_check_datapath_enable_register.sv | 21 ++
 rtl/array_sort_check_datapath.sv | 94 +++++++++
 tb/tb_array_sort_check_datapath.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_sort_check_pkg.sv
// Shared definitions for the array-sort-check controller/datapath pair:
// default widths, select_index encodings and the element compare mode.
package array_sort_check_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LEN_W      = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ELEM_BYTES = 4;

  localparam logic SEL_CLEAR = 1'b0;
  localparam logic SEL_NEXT  = 1'b1;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

endpackage

// File: rtl/array_sort_check_datapath_enable_register.sv
// Plain register with synchronous active-high reset and a write enable;
// every piece of datapath state is held in one of these.
module enable_register #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/array_sort_check_datapath.sv
// Datapath for the array-sort-check controller: walks an element index over
// an array in memory and flags adjacent-element inversions.
module array_sort_check_datapath
  import array_sort_check_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ELEM_BYTES = DEF_ELEM_BYTES,  // power of two
  parameter int SIGNED_CMP = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_input,
  input  logic              load_index,
  input  logic              select_index,
  input  logic [ADDR_W-1:0] array_start,
  input  logic [LEN_W-1:0]  array_length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inversion_found,
  output logic              end_of_array,
  output logic              zero_length_array,
  output logic [LEN_W-1:0]  compare_count
);

  localparam int        STRIDE_SH = $clog2(ELEM_BYTES);
  localparam cmp_mode_e CMP_MODE  = (SIGNED_CMP != 0) ? CMP_SIGNED : CMP_UNSIGNED;

  logic [ADDR_W-1:0] start;
  logic [LEN_W-1:0]  length;
  logic [LEN_W-1:0]  index;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic [LEN_W-1:0]  count;

  logic [LEN_W:0]    index_inc;
  logic              can_advance;
  logic              clear_idx;
  logic              advance;
  logic              idx_en;
  logic [LEN_W-1:0]  index_d;
  logic [LEN_W-1:0]  count_d;
  logic [ADDR_W-1:0] index_ext;
  logic              prev_greater;

  // One extra bit keeps index+1 exact even for the largest representable length.
  assign index_inc   = {1'b0, index} + {{LEN_W{1'b0}}, 1'b1};
  assign can_advance = index_inc < {1'b0, length};

  // load_input outranks load_index; advance is suppressed on the last element.
  assign clear_idx = load_input | (load_index & (select_index == SEL_CLEAR));
  assign advance   = ~load_input & load_index & (select_index == SEL_NEXT) & can_advance;
  assign idx_en    = clear_idx | advance;
  assign index_d   = clear_idx ? '0 : index_inc[LEN_W-1:0];
  assign count_d   = clear_idx ? '0 : count + {{(LEN_W-1){1'b0}}, 1'b1};

  enable_register #(.WIDTH(ADDR_W)) u_start (
    .clock(clock), .reset(reset), .enable(load_input), .d(array_start), .q(start)
  );

  enable_register #(.WIDTH(LEN_W)) u_length (
    .clock(clock), .reset(reset), .enable(load_input), .d(array_length), .q(length)
  );

  enable_register #(.WIDTH(LEN_W)) u_index (
    .clock(clock), .reset(reset), .enable(idx_en), .d(index_d), .q(index)
  );

  enable_register #(.WIDTH(DATA_W)) u_prev (
    .clock(clock), .reset(reset), .enable(advance), .d(mem_rdata), .q(prev)
  );

  enable_register #(.WIDTH(1)) u_prev_valid (
    .clock(clock), .reset(reset), .enable(idx_en), .d(~clear_idx), .q(prev_valid)
  );

  enable_register #(.WIDTH(LEN_W)) u_count (
    .clock(clock), .reset(reset), .enable(idx_en), .d(count_d), .q(count)
  );

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign index_ext = ADDR_W'(index);
  assign mem_addr  = start + (index_ext << STRIDE_SH);

  assign prev_greater = (CMP_MODE == CMP_SIGNED) ? ($signed(prev) > $signed(mem_rdata))
                                                 : (prev > mem_rdata);

  assign zero_length_array = (length == '0);
  assign end_of_array      = zero_length_array | ~can_advance;
  assign inversion_found   = prev_valid & prev_greater & ~zero_length_array;
  assign compare_count     = count;

endmodule

// File: tb/tb_array_sort_check_datapath.sv
// Directed bench for array_sort_check_datapath: signed and unsigned instances
// share stimulus and are checked each cycle against an index-level model.
module tb_array_sort_check_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_input;
  logic        load_index;
  logic        select_index;
  logic [31:0] array_start;
  logic [15:0] array_length;
  logic [31:0] mem_rdata;

  logic [31:0] mem_addr, mem_addr_u;
  logic        inv_s, inv_u;
  logic        eoa, eoa_u;
  logic        zero, zero_u;
  logic [15:0] cnt, cnt_u;

  logic [31:0] mem_img [16];

  int n_cmp = 0;
  int n_bad = 0;
  logic checking = 1'b0;

  always #5 clock = ~clock;

  // Word-addressed memory image; combinational read.
  assign mem_rdata = mem_img[mem_addr[5:2]];

  array_sort_check_datapath #(.SIGNED_CMP(1)) dut (
    .clock(clock), .reset(reset), .load_input(load_input), .load_index(load_index),
    .select_index(select_index), .array_start(array_start), .array_length(array_length),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .inversion_found(inv_s),
    .end_of_array(eoa), .zero_length_array(zero), .compare_count(cnt)
  );

  array_sort_check_datapath #(.SIGNED_CMP(0)) dut_u (
    .clock(clock), .reset(reset), .load_input(load_input), .load_index(load_index),
    .select_index(select_index), .array_start(array_start), .array_length(array_length),
    .mem_addr(mem_addr_u), .mem_rdata(mem_rdata), .inversion_found(inv_u),
    .end_of_array(eoa_u), .zero_length_array(zero_u), .compare_count(cnt_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the array is seen as (start, length) plus a position and an advance tally.
  logic [31:0] m_start = '0;
  logic [31:0] m_len   = '0;
  logic [31:0] m_idx   = '0;
  logic [31:0] m_count = '0;

  function automatic logic [31:0] elem(input logic [31:0] i);
    logic [31:0] a;
    a = m_start + (i * 32'd4);
    return mem_img[a[5:2]];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_start <= '0; m_len <= '0; m_idx <= '0; m_count <= '0;
    end else if (load_input) begin
      m_start <= array_start; m_len <= {16'd0, array_length};
      m_idx <= '0; m_count <= '0;
    end else if (load_index && !select_index) begin
      m_idx <= '0; m_count <= '0;
    end else if (load_index && select_index && (m_idx + 1 < m_len)) begin
      m_idx <= m_idx + 1; m_count <= m_count + 1;
    end
  end

  always @(negedge clock) begin
    logic [31:0] a, b;
    logic        e_zero, e_eoa, e_inv_s, e_inv_u;
    if (checking) begin
      e_zero  = (m_len == 0);
      e_eoa   = e_zero || (m_idx + 1 >= m_len);
      e_inv_s = 1'b0;
      e_inv_u = 1'b0;
      if (!e_zero && m_idx > 0) begin
        a = elem(m_idx - 1);
        b = elem(m_idx);
        e_inv_s = $signed(a) > $signed(b);
        e_inv_u = a > b;
      end
      check("model_mem_addr", mem_addr, m_start + m_idx * 32'd4);
      check("model_zero_length", {31'd0, zero}, {31'd0, e_zero});
      check("model_end_of_array", {31'd0, eoa}, {31'd0, e_eoa});
      check("model_inversion_signed", {31'd0, inv_s}, {31'd0, e_inv_s});
      check("model_inversion_unsigned", {31'd0, inv_u}, {31'd0, e_inv_u});
      check("model_compare_count", {16'd0, cnt}, m_count);
    end
  end

  // One clock edge with the given controls, released afterwards.
  task automatic cyc(input logic li, input logic lx, input logic sel);
    load_input = li; load_index = lx; select_index = sel;
    @(posedge clock); #1;
    load_input = 1'b0; load_index = 1'b0;
  endtask

  task automatic load_arr(input logic [31:0] s, input logic [15:0] n,
                          input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] a;
    array_start = s; array_length = n;
    cyc(1'b1, 1'b0, 1'b0);
    // Memory changes only once the index is back at 0.
    a = s;       mem_img[a[5:2]] = v0;
    a = s + 4;   mem_img[a[5:2]] = v1;
    a = s + 8;   mem_img[a[5:2]] = v2;
    a = s + 12;  mem_img[a[5:2]] = v3;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge clock);
    check(name, act, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_img[i] = '0;
    reset = 1'b1; load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;
    array_start = '0; array_length = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    checking = 1'b1;

    lit("reset_mem_addr", mem_addr, 32'h0);
    lit("reset_zero_length", {31'd0, zero}, 32'd1);
    lit("reset_end_of_array", {31'd0, eoa}, 32'd1);
    lit("reset_inversion", {31'd0, inv_s}, 32'd0);
    lit("reset_count", {16'd0, cnt}, 32'd0);

    // Sorted walk [1,3,3,7]
    load_arr(32'h1000, 16'd4, 32'd1, 32'd3, 32'd3, 32'd7);
    lit("walk_addr0", mem_addr, 32'h1000);
    lit("walk_eoa0", {31'd0, eoa}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      lit("walk_addr", mem_addr, 32'h1004 + 32'(k) * 32'd4);
      lit("walk_inversion", {31'd0, inv_s}, 32'd0);
    end
    lit("walk_eoa3", {31'd0, eoa}, 32'd1);
    lit("walk_count3", {16'd0, cnt}, 32'd3);
    cyc(1'b0, 1'b1, 1'b1);
    lit("walk_hold_addr", mem_addr, 32'h100C);
    lit("walk_hold_count", {16'd0, cnt}, 32'd3);
    cyc(1'b0, 1'b1, 1'b0);
    lit("clear_addr", mem_addr, 32'h1000);
    lit("clear_count", {16'd0, cnt}, 32'd0);

    // Signed inversion [5,-2]
    load_arr(32'h2000, 16'd2, 32'd5, 32'hFFFF_FFFE, 32'd0, 32'd0);
    lit("signed_pre_inversion", {31'd0, inv_s}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    lit("signed_inversion", {31'd0, inv_s}, 32'd1);
    lit("unsigned_inversion", {31'd0, inv_u}, 32'd0);
    lit("signed_eoa", {31'd0, eoa}, 32'd1);

    // Length 1
    load_arr(32'h3000, 16'd1, 32'd9, 32'd0, 32'd0, 32'd0);
    lit("len1_eoa", {31'd0, eoa}, 32'd1);
    lit("len1_inversion", {31'd0, inv_s}, 32'd0);

    // Zero length
    load_arr(32'h4000, 16'd0, 32'd8, 32'd1, 32'd0, 32'd0);
    lit("zero_flag", {31'd0, zero}, 32'd1);
    lit("zero_eoa", {31'd0, eoa}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    lit("zero_addr_hold", mem_addr, 32'h4000);
    lit("zero_inversion", {31'd0, inv_s}, 32'd0);

    // Priority of load_input over load_index, then mid-scan reset
    load_arr(32'h1000, 16'd4, 32'd1, 32'd3, 32'd3, 32'd7);
    cyc(1'b0, 1'b1, 1'b1);
    lit("prio_pre_addr", mem_addr, 32'h1004);
    array_length = 16'd5;
    cyc(1'b1, 1'b1, 1'b1);
    lit("prio_addr", mem_addr, 32'h1000);
    lit("prio_count", {16'd0, cnt}, 32'd0);
    lit("prio_eoa", {31'd0, eoa}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    lit("midreset_pre_addr", mem_addr, 32'h1008);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    lit("midreset_addr", mem_addr, 32'h0);
    lit("midreset_zero", {31'd0, zero}, 32'd1);
    lit("midreset_count", {16'd0, cnt}, 32'd0);

    // Address wrap with a descending pair
    load_arr(32'hFFFF_FFFC, 16'd2, 32'd9, 32'd4, 32'd0, 32'd0);
    lit("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b1);
    lit("wrap_addr1", mem_addr, 32'h0);
    lit("wrap_inversion", {31'd0, inv_s}, 32'd1);

    // Largest length
    load_arr(32'h0, 16'hFFFF, 32'd2, 32'd4, 32'd1, 32'd6);
    lit("maxlen_eoa", {31'd0, eoa}, 32'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1);
    lit("maxlen_count", {16'd0, cnt}, 32'd3);

    repeat (2) @(posedge clock);
    @(negedge clock);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
